// File: rtl/ex_operand_stage.sv
// ID/EX operand register: captures decoded operands with EX/MEM and MEM/WB forwarding,
// supports stall (with operand refresh from retiring producers) and flush to a bubble.

module ex_fwd_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] dflt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] val
);
  always_comb begin
    val = dflt;
    if (idx == '0)                                val = '0;
    else if (mem_reg_write && mem_rd_addr == idx) val = mem_result;
    else if (wb_reg_write && wb_rd_addr == idx)   val = wb_data;
  end
endmodule

module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [CTRL_W-1:0] ALU_control,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write
);
  localparam int NFWD = 4;
  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(2);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] rs2_data;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              reg_write;
    logic              alu_src;
  } ex_reg_t;

  ex_reg_t q, nxt, bubble;

  // Slots 0/1 forward the incoming ID sources; slots 2/3 refresh the held operands during a stall.
  logic [NFWD-1:0][REG_AW-1:0] f_idx;
  logic [NFWD-1:0][DATA_W-1:0] f_dflt;
  logic [NFWD-1:0][DATA_W-1:0] f_val;

  assign f_idx  = {q.rs2, q.rs1, id_rs2_addr, id_rs1_addr};
  assign f_dflt = {q.rs2_data, q.src1, id_rs2_data, id_rs1_data};

  for (genvar g = 0; g < NFWD; g++) begin : g_fwd
    ex_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
      .idx           (f_idx[g]),
      .dflt          (f_dflt[g]),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_data       (wb_data),
      .val           (f_val[g])
    );
  end

  always_comb begin
    bubble      = '0;
    bubble.ctrl = CTRL_ADD;
    nxt         = q;
    if (flush) begin
      nxt = bubble;
    end else if (stall) begin
      // Bubble indices are 0, so a stalled bubble never picks up forwarded data.
      nxt.src1     = f_val[2];
      nxt.rs2_data = f_val[3];
      if (!q.alu_src) nxt.src2 = f_val[3];
    end else if (!id_valid) begin
      nxt = bubble;
    end else begin
      nxt.valid     = 1'b1;
      nxt.src1      = f_val[0];
      nxt.src2      = id_alu_src ? id_imm : f_val[1];
      nxt.rs2_data  = f_val[1];
      nxt.ctrl      = id_alu_control;
      nxt.rd        = id_rd_addr;
      nxt.rs1       = id_rs1_addr;
      nxt.rs2       = id_rs2_addr;
      nxt.reg_write = id_reg_write;
      nxt.alu_src   = id_alu_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= bubble;
    else     q <= nxt;
  end

  assign ex_valid     = q.valid;
  assign src1         = q.src1;
  assign src2         = q.src2;
  assign ALU_control  = q.ctrl;
  assign ex_rs2_data  = q.rs2_data;
  assign ex_rd_addr   = q.rd;
  assign ex_reg_write = q.reg_write & q.valid;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding priority, stall refresh, flush.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src, id_reg_write;
  logic [3:0]  id_alu_control;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_data;
  logic        ex_valid, ex_reg_write;
  logic [31:0] src1, src2, ex_rs2_data;
  logic [3:0]  ALU_control;
  logic [4:0]  ex_rd_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .src1(src1), .src2(src2), .ALU_control(ALU_control),
    .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; stall = 0; flush = 0; id_valid = 1;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alu_src = 0; id_alu_control = 4'b0010; id_rd_addr = 0; id_reg_write = 0;
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".src1"}, src1, 32'd0);
    chk({tag, ".src2"}, src2, 32'd0);
    chk({tag, ".rs2d"}, ex_rs2_data, 32'd0);
    chk({tag, ".ctrl"}, 32'(ALU_control), 32'h2);
    chk({tag, ".rd"}, 32'(ex_rd_addr), 32'd0);
    chk({tag, ".we"}, 32'(ex_reg_write), 32'd0);
  endtask

  initial begin
    // Reset with random ID/forwarding inputs
    quiet();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1; id_reg_write = 1;
      id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom); id_rd_addr = 5'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_control = 4'($urandom); mem_reg_write = 1; mem_result = $urandom;
      stall = 1'($urandom);
      step();
    end
    chk_bubble("reset");

    // add r3 = r1 + r2, no hazards
    quiet();
    id_rs1_addr = 1; id_rs1_data = 5; id_rs2_addr = 2; id_rs2_data = 7;
    id_rd_addr = 3; id_reg_write = 1;
    step();
    chk("add.valid", 32'(ex_valid), 32'd1);
    chk("add.src1", src1, 32'd5);
    chk("add.src2", src2, 32'd7);
    chk("add.ctrl", 32'(ALU_control), 32'h2);
    chk("add.rd", 32'(ex_rd_addr), 32'd3);
    chk("add.we", 32'(ex_reg_write), 32'd1);

    // Double hazard on r4: EX/MEM wins; rs2=0 stays zero despite nonzero read data
    quiet();
    id_rs1_addr = 4; id_rs1_data = 32'h1; id_rs2_addr = 0; id_rs2_data = 32'h55;
    mem_reg_write = 1; mem_rd_addr = 4; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd_addr = 4; wb_data = 32'h22;
    step();
    chk("dh.mem", src1, 32'h11);
    chk("dh.r0src2", src2, 32'h0);
    mem_reg_write = 0;
    step();
    chk("dh.wb", src1, 32'h22);
    quiet();
    id_rs1_addr = 0; id_rs1_data = 9; mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'h33;
    step();
    chk("dh.r0", src1, 32'h0);

    // Stall: WB producer of r6 retires while the consumer is held in EX
    quiet();
    id_rs1_addr = 1; id_rs1_data = 3; id_rs2_addr = 6; id_rs2_data = 32'h10;
    id_alu_control = 4'b0110; id_rd_addr = 7; id_reg_write = 1;
    step();
    chk("st.cap", src2, 32'h10);
    stall = 1;
    id_alu_control = 4'b0111; id_rd_addr = 9; id_rs2_addr = 8; id_rs2_data = 32'hDEAD;
    wb_reg_write = 1; wb_rd_addr = 6; wb_data = 32'hABCD;
    step();
    chk("st.src2", src2, 32'hABCD);
    chk("st.rs2d", ex_rs2_data, 32'hABCD);
    chk("st.src1", src1, 32'd3);
    chk("st.ctrl", 32'(ALU_control), 32'h6);
    chk("st.rd", 32'(ex_rd_addr), 32'd7);
    chk("st.valid", 32'(ex_valid), 32'd1);
    wb_reg_write = 0;
    mem_reg_write = 1; mem_rd_addr = 1; mem_result = 32'h77;
    step();
    chk("st.hold2", src2, 32'hABCD);
    chk("st.src1mem", src1, 32'h77);
    chk("st.we", 32'(ex_reg_write), 32'd1);

    // Immediate operand: src2 = imm, store data forwarded from EX/MEM
    quiet();
    id_alu_src = 1; id_imm = 32'hFFFFFFF0; id_rs2_addr = 2; id_rs2_data = 32'h4;
    id_rd_addr = 5; id_reg_write = 1;
    mem_reg_write = 1; mem_rd_addr = 2; mem_result = 32'h99;
    step();
    chk("imm.src2", src2, 32'hFFFFFFF0);
    chk("imm.rs2d", ex_rs2_data, 32'h99);
    stall = 1; mem_result = 32'h1234;
    step();
    chk("imm.st.src2", src2, 32'hFFFFFFF0);
    chk("imm.st.rs2d", ex_rs2_data, 32'h1234);

    // Flush beats stall
    flush = 1;
    step();
    chk_bubble("flush");

    // Valid with reg_write=0, then id_valid=0 produces a bubble
    quiet();
    id_rs1_addr = 1; id_rs1_data = 32'hA; id_rd_addr = 4; id_reg_write = 0;
    step();
    chk("nowr.valid", 32'(ex_valid), 32'd1);
    chk("nowr.we", 32'(ex_reg_write), 32'd0);
    chk("nowr.src1", src1, 32'hA);
    id_valid = 0; id_reg_write = 1; id_rd_addr = 9; id_rs2_addr = 3; id_rs2_data = 32'h5;
    step();
    chk_bubble("inval");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
